// File: rtl/scan_doubler_pkg.sv
// Shared constants and buffer word layout for the 15 kHz -> 31 kHz scan doubler.
package scan_doubler_pkg;

    // Pixel colour bits, packed as {BLUE,GREEN,RED}.
    localparam int COLOR_W  = 3;
    // Maximum stored pixels per source line (power of two).
    localparam int MAX_LINE = 512;
    // Address width inside one line bank.
    localparam int ADDR_W   = $clog2(MAX_LINE);
    // Clock cycles per source pixel (even, at least 2).
    localparam int CE_DIV   = 4;

    // One stored pixel: the source hsync level travels with the colour so the
    // replayed line carries its own sync pulse.
    typedef struct packed {
        logic               hs_n;
        logic [COLOR_W-1:0] rgb;
    } buf_word_t;

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line store: two banks of MAX_LINE words, bank selected by the
// address MSB. One write port, one registered read port (1 clk latency).
module line_buffer_dp
    import scan_doubler_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ADDR_W:0]  wr_addr,
    input  logic [COLOR_W:0] wr_data,
    input  logic [ADDR_W:0]  rd_addr,
    output logic [COLOR_W:0] rd_data
);

    buf_word_t mem [0:2*MAX_LINE-1];

    // Write and registered read; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= buf_word_t'(wr_data);
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/scan_doubler.sv
// Scan doubler: stores each 15 kHz source line in one bank while the previous
// line is replayed twice from the other bank at twice the pixel rate.
module scan_doubler
    import scan_doubler_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    input  logic               in_hs_n,
    input  logic               in_vs_n,
    input  logic [COLOR_W-1:0] in_rgb,
    output logic               vga_hs_n,
    output logic               vga_vs_n,
    output logic [COLOR_W-1:0] vga_rgb,
    output logic               line_valid
);

    localparam int              PH_W    = $clog2(CE_DIV);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CE_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CE_DIV / 2);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LINE);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [PH_W-1:0]   phase;
    logic              out_ce;
    logic              hs_prev;
    logic              swap;
    logic              wbank;
    logic [ADDR_W:0]   wcount;
    logic [ADDR_W:0]   line_len;
    logic [ADDR_W-1:0] rptr;
    logic              vs_line;
    logic              seen_one;

    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [COLOR_W:0]  wr_data;
    logic [ADDR_W:0]   rd_addr;
    logic [COLOR_W:0]  rd_data;
    buf_word_t         rd_word;

    logic              vld_p1;
    logic              zero_p1;

    // Two output slots per source pixel; a source strobe marks phase 0.
    assign out_ce = (phase == '0) || (phase == PH_HALF);
    // Falling edge of the sampled source hsync starts a new line.
    assign swap   = pix_ce && !in_hs_n && hs_prev;

    // Free-running phase counter, resynchronised by every source pixel strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (pix_ce) begin
            phase <= PH_ONE;
        end else if (phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_ONE;
        end
    end

    // Write-side bookkeeping: pixel count, bank swap, line length, vsync latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev    <= 1'b1;
            wbank      <= 1'b0;
            wcount     <= '0;
            line_len   <= '0;
            vs_line    <= 1'b1;
            seen_one   <= 1'b0;
            line_valid <= 1'b0;
        end else if (pix_ce) begin
            hs_prev <= in_hs_n;
            if (swap) begin
                line_len <= wcount;
                wbank    <= ~wbank;
                wcount   <= LEN_ONE;
                vs_line  <= in_vs_n;
                seen_one <= 1'b1;
                if (seen_one) begin
                    line_valid <= 1'b1;
                end
            end else if (wcount != LEN_MAX) begin
                wcount <= wcount + LEN_ONE;
            end
        end
    end

    // RAM port steering: the swap pixel lands at address 0 of the fresh bank,
    // and pixels past MAX_LINE are dropped.
    always_comb begin
        wr_en   = pix_ce && (swap || (wcount != LEN_MAX));
        wr_addr = swap ? {~wbank, {ADDR_W{1'b0}}} : {wbank, wcount[ADDR_W-1:0]};
        wr_data = {in_hs_n, in_rgb};
        rd_addr = {~wbank, rptr};
    end

    line_buffer_dp u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Read pointer: wraps at the measured length so the line replays; a swap
    // restarts it and consumes any coincident output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
        end else if (swap) begin
            rptr <= '0;
        end else if (out_ce) begin
            if ((line_len == '0) || (({1'b0, rptr} + LEN_ONE) >= line_len)) begin
                rptr <= '0;
            end else begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // ---- stage p1: RAM word in flight, slot strobe and line-start flag follow it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            zero_p1 <= 1'b0;
        end else begin
            vld_p1  <= out_ce && !swap;
            zero_p1 <= (rptr == '0);
        end
    end

    assign rd_word = buf_word_t'(rd_data);

    // ---- stage p2: output register; blanked during sync, idle until a full line exists
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs_n <= 1'b1;
            vga_vs_n <= 1'b1;
            vga_rgb  <= '0;
        end else if (!line_valid) begin
            vga_hs_n <= 1'b1;
            vga_vs_n <= 1'b1;
            vga_rgb  <= '0;
        end else if (vld_p1) begin
            vga_hs_n <= rd_word.hs_n;
            vga_rgb  <= rd_word.hs_n ? rd_word.rgb : '0;
            if (zero_p1) begin
                vga_vs_n <= vs_line;
            end
        end
    end

endmodule

// File: tb/tb_scan_doubler.sv
// Directed bench for scan_doubler: source lines are driven pixel by pixel, the
// outputs are logged once per clock (on the falling edge) and replays are
// compared against the hand-derived pixel pattern afterwards.
module tb_scan_doubler;

    localparam int LOGN = 32768;
    localparam int BIG  = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic       in_hs_n = 1'b1;
    logic       in_vs_n = 1'b1;
    logic [2:0] in_rgb = 3'd0;
    logic       vga_hs_n;
    logic       vga_vs_n;
    logic [2:0] vga_rgb;
    logic       line_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s_line [0:15];
    // {line_valid, vga_vs_n, vga_hs_n, vga_rgb} seen after posedge number idx
    logic [5:0] log_w [0:LOGN-1];

    scan_doubler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_ce     (pix_ce),
        .in_hs_n    (in_hs_n),
        .in_vs_n    (in_vs_n),
        .in_rgb     (in_rgb),
        .vga_hs_n   (vga_hs_n),
        .vga_vs_n   (vga_vs_n),
        .vga_rgb    (vga_rgb),
        .line_valid (line_valid)
    );

    always #5 clk = ~clk;

    // Count rising edges; index k in the log means "after rising edge k".
    always @(posedge clk) cyc <= cyc + 1;

    // Log outputs mid-cycle.
    always @(negedge clk) begin
        if (cyc < LOGN) log_w[cyc] <= {line_valid, vga_vs_n, vga_hs_n, vga_rgb};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {hs_n, rgb} for source pixel p: sync for pixels 0..31, then p%8.
    function automatic logic [3:0] exp_word(input int p);
        if (p < 32) return 4'b0000;
        return {1'b1, 3'(p % 8)};
    endfunction

    // Called on a falling edge; strobes one pixel and leaves 'gap' clocks.
    task automatic px(input logic hs, input logic vs, input logic [2:0] rgb, input int gap);
        pix_ce  = 1'b1;
        in_hs_n = hs;
        in_vs_n = vs;
        in_rgb  = rgb;
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_line(input int idx, input int len, input logic vs0, input int shift_at);
        s_line[idx] = cyc + 1;
        for (int k = 0; k < len; k++) begin
            px((k < 32) ? 1'b0 : 1'b1, (k == 0) ? vs0 : 1'b1, 3'(k % 8),
               (k == shift_at) ? 5 : 4);
        end
    endtask

    // Replay slot j of the line starting at rising edge s shows at s+3+2j
    // (one clk later from slot shift_j on).
    task automatic check_replay(input string tag, input int s, input int len, input int shift_j);
        for (int j = 0; j < 767; j++) begin
            int idx;
            idx = s + 3 + 2 * j + ((j >= shift_j) ? 1 : 0);
            check($sformatf("%s[%0d]", tag, j), 32'(log_w[idx][3:0]), 32'(exp_word(j % len)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int j;
        // Reset held with random activity on the inputs.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pix_ce  = 1'($urandom_range(0, 1));
            in_hs_n = 1'($urandom_range(0, 1));
            in_vs_n = 1'($urandom_range(0, 1));
            in_rgb  = 3'($urandom_range(0, 7));
            check($sformatf("rst_hold[%0d]", i),
                  32'({line_valid, vga_vs_n, vga_hs_n, vga_rgb}), 32'(6'b011000));
        end
        @(negedge clk);
        pix_ce  = 1'b0;
        in_hs_n = 1'b1;
        in_vs_n = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);

        // No hsync edges: nothing may come out.
        for (int k = 0; k < 100; k++) px(1'b1, 1'b1, 3'(k), 4);
        check("idle", 32'({line_valid, vga_vs_n, vga_hs_n, vga_rgb}), 32'(6'b011000));

        send_line(1, 384, 1'b1, -1);
        check("lv_one_swap", 32'(line_valid), 32'd0);
        send_line(2, 384, 1'b1, -1);
        send_line(3, 384, 1'b1, -1);
        send_line(4, 384, 1'b0, -1);
        send_line(5, 200, 1'b1, -1);
        send_line(6, 384, 1'b1, -1);
        send_line(7, 600, 1'b1, -1);
        send_line(8, 384, 1'b1, -1);
        send_line(9, 384, 1'b1, 100);
        send_line(10, 240, 1'b0, -1);

        // Mid-line: line 9 replaying with vsync low, then an async reset.
        j = (cyc - s_line[10] - 3) / 2;
        check("pre_rst", 32'({line_valid, vga_vs_n, vga_hs_n, vga_rgb}),
              32'({2'b10, exp_word(j % 384)}));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({line_valid, vga_vs_n, vga_hs_n, vga_rgb}), 32'(6'b011000));
        @(negedge clk);
        rst_n = 1'b1;

        send_line(11, 384, 1'b1, -1);
        check("lv_after_rst_one", 32'(line_valid), 32'd0);
        send_line(12, 64, 1'b1, -1);
        @(negedge clk);

        // line_valid rises exactly at the second swap.
        check("lv_pre", 32'(log_w[s_line[2] - 1]), 32'(6'b011000));
        check("lv_set", 32'(log_w[s_line[2]][5]), 32'd1);
        check("lv_rst_pre", 32'(log_w[s_line[12] - 1][5]), 32'd0);
        check("lv_rst_set", 32'(log_w[s_line[12]][5]), 32'd1);
        check("rst_replay0", 32'(log_w[s_line[12] + 3][3:0]), 32'(exp_word(0)));
        check("rst_replay40", 32'(log_w[s_line[12] + 83][3:0]), 32'(exp_word(40)));

        // Nominal replays of 384-pixel lines.
        check_replay("l2", s_line[2], 384, BIG);
        check_replay("l3", s_line[3], 384, BIG);
        // Slot consumed by the swap holds the last replayed pixel (382).
        check("swap_hold", 32'(log_w[s_line[3] + 2][3:0]), 32'(exp_word(382)));

        // Vsync follows the line-start pixel of the replay.
        check("vs_before", 32'(log_w[s_line[4] + 2][4]), 32'd1);
        check("vs_low", 32'(log_w[s_line[4] + 3][4]), 32'd0);
        check("vs_hold", 32'(log_w[s_line[4] + 1000][4]), 32'd0);
        check("vs_end_before", 32'(log_w[s_line[5] + 2][4]), 32'd0);
        check("vs_high", 32'(log_w[s_line[5] + 3][4]), 32'd1);

        // Shorter line, overflowing line, and a 1-clk source shift.
        check_replay("len200", s_line[6], 200, BIG);
        check_replay("ovf", s_line[8], 512, BIG);
        check_replay("resync", s_line[9], 384, 202);
        check("resync_old", 32'(log_w[s_line[9] + 3 + 404][3:0]), 32'(exp_word(201)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
